// File: rtl/skolem_witness_gen_pkg.sv
// Shared types for the Skolem witness generator: FSM state encoding, the
// cyclic i_10/i_11/i_12 chain record and a constant-width helper.
// No ports; imported by the interface-facing modules.
package skolem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic i10;
    logic i11;
    logic i12;
  } chain_t;

  localparam int CHAIN_W = 3;

  // Ceiling log2, at least 1 for v <= 2 so counters are never zero-width.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/skolem_witness_gen_if.sv
// Handshake bundle for skolem_witness_gen: request side (in_valid/in_ready,
// x_a, x_b) and witness side (out_valid/out_ready, sum, carry, i_*, fp_fail).
// Modports: slave = generator, master = producer/consumer. WITNESS_CHECK_EN adds check_ok.
interface skolem_witness_gen_if #(
  parameter int ADD_W = 2
) ();
  logic             in_valid;
  logic             in_ready;
  logic [ADD_W-1:0] x_a;
  logic [ADD_W-1:0] x_b;
  logic             out_valid;
  logic             out_ready;
  logic [ADD_W-1:0] sum;
  logic             carry;
  logic             i_1;
  logic             i_9;
  logic             i_10;
  logic             i_11;
  logic             i_12;
  logic             fp_fail;
`ifdef WITNESS_CHECK_EN
  logic             check_ok;

  modport slave (
    input  in_valid, x_a, x_b, out_ready,
    output in_ready, out_valid, sum, carry, i_1, i_9, i_10, i_11, i_12, fp_fail, check_ok
  );
  modport master (
    output in_valid, x_a, x_b, out_ready,
    input  in_ready, out_valid, sum, carry, i_1, i_9, i_10, i_11, i_12, fp_fail, check_ok
  );
`else
  modport slave (
    input  in_valid, x_a, x_b, out_ready,
    output in_ready, out_valid, sum, carry, i_1, i_9, i_10, i_11, i_12, fp_fail
  );
  modport master (
    output in_valid, x_a, x_b, out_ready,
    input  in_ready, out_valid, sum, carry, i_1, i_9, i_10, i_11, i_12, fp_fail
  );
`endif
endinterface

// File: rtl/skolem_witness_gen_fix_step.sv
// One Jacobi step of the cyclic chain: next = f(x_0, x_4, x_5, cur), purely combinational.
// Ports: x_0, x_4, x_5 (latched universal bits), cur (current chain), nxt (updated chain).
// A chain is a fixed point exactly when nxt == cur.
module skolem_fix_step
  import skolem_pkg::*;
(
  input  logic   x_0,
  input  logic   x_4,
  input  logic   x_5,
  input  chain_t cur,
  output chain_t nxt
);

  assign nxt.i10 = x_0 | cur.i12;
  assign nxt.i11 = x_4 & cur.i10;
  assign nxt.i12 = x_5 | cur.i11;

endmodule

// File: rtl/skolem_witness_gen.sv
// Skolem witness generator for the 2-bit-adder relation: bit-serial add, then
// fixed-point iteration of the i_10/i_11/i_12 chain from all-zero (least fixed point).
// Ports: clk, rst (async, active-high), bus (skolem_witness_gen_if.slave).
// Macro WITNESS_CHECK_EN adds bus.check_ok, a combinational relation check in DONE.
module skolem_witness_gen
  import skolem_pkg::*;
#(
  parameter int ADD_W    = 2,
  parameter int MAX_ITER = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  skolem_witness_gen_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ADD  = ADD;
  localparam logic [1:0] ST_FIX  = FIX;
  localparam logic [1:0] ST_DONE = DONE;

  localparam int BIT_W = clog2(ADD_W + 1);
  localparam int CNT_W = clog2(MAX_ITER + 1);

  logic [1:0]       state_q;
  logic [ADD_W-1:0] a_sh;
  logic [ADD_W-1:0] b_sh;
  logic [ADD_W-1:0] sum_q;
  logic             c_q;
  logic             x0_q;
  logic             x4_q;
  logic             x5_q;
  chain_t           chain_q;
  logic             fp_fail_q;
  logic             i1_q;
  logic [BIT_W-1:0] bit_q;
  logic [CNT_W-1:0] iter_q;

  logic             s_bit;
  logic             c_nxt;
  logic [ADD_W-1:0] sum_nxt;
  logic             bit_last;
  logic             iter_last;
  chain_t           chain_nxt;
  logic             i9;

  assign i9 = 1'b0;

  // Operands are shifted right each ADD cycle so the current bit is always [0];
  // the sum bit enters at the MSB and lands at its final position after ADD_W shifts.
  always_comb begin
    s_bit          = a_sh[0] ^ b_sh[0] ^ c_q;
    c_nxt          = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_q) | (b_sh[0] & c_q);
    sum_nxt        = sum_q >> 1;
    sum_nxt[ADD_W-1] = s_bit;
  end

  assign bit_last  = (bit_q == BIT_W'(ADD_W - 1));
  // iter_q counts steps already loaded, so this cycle is step iter_q+1.
  assign iter_last = (iter_q == CNT_W'(MAX_ITER - 1));

  skolem_fix_step u_step (
    .x_0 (x0_q),
    .x_4 (x4_q),
    .x_5 (x5_q),
    .cur (chain_q),
    .nxt (chain_nxt)
  );

`ifdef WITNESS_CHECK_EN
  logic [ADD_W-1:0] a_q;
  logic [ADD_W-1:0] b_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_q     <= '0;
      c_q       <= 1'b0;
      x0_q      <= 1'b0;
      x4_q      <= 1'b0;
      x5_q      <= 1'b0;
      chain_q   <= '0;
      fp_fail_q <= 1'b0;
      i1_q      <= 1'b0;
      bit_q     <= '0;
      iter_q    <= '0;
`ifdef WITNESS_CHECK_EN
      a_q       <= '0;
      b_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sh      <= bus.x_a;
            b_sh      <= bus.x_b;
            x0_q      <= bus.x_a[0];
            x4_q      <= bus.x_a[ADD_W-1];
            x5_q      <= bus.x_b[0];
            sum_q     <= '0;
            c_q       <= 1'b0;
            chain_q   <= '0;
            fp_fail_q <= 1'b0;
            i1_q      <= 1'b0;
            bit_q     <= '0;
            iter_q    <= '0;
`ifdef WITNESS_CHECK_EN
            a_q       <= bus.x_a;
            b_q       <= bus.x_b;
`endif
            state_q   <= ST_ADD;
          end
        end
        ST_ADD: begin
          sum_q <= sum_nxt;
          c_q   <= c_nxt;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          bit_q <= bit_q + BIT_W'(1);
          if (bit_last) state_q <= ST_FIX;
        end
        ST_FIX: begin
          // On failure the chain keeps its last loaded value rather than the
          // unconverged next step, so outputs never show a half-finished update.
          if (chain_nxt == chain_q) begin
            fp_fail_q <= 1'b0;
            i1_q      <= 1'b1;
            state_q   <= ST_DONE;
          end else if (iter_last) begin
            fp_fail_q <= 1'b1;
            i1_q      <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            chain_q <= chain_nxt;
            iter_q  <= iter_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.carry     = c_q;
  assign bus.i_1       = i1_q;
  assign bus.i_9       = i9;
  assign bus.i_10      = chain_q.i10;
  assign bus.i_11      = chain_q.i11;
  assign bus.i_12      = chain_q.i12;
  assign bus.fp_fail   = fp_fail_q;

`ifdef WITNESS_CHECK_EN
  logic [ADD_W:0] ref_sum;
  assign ref_sum = {1'b0, a_q} + {1'b0, b_q};
  assign bus.check_ok = (state_q == ST_DONE)
                      && (ref_sum == {c_q, sum_q})
                      && (i1_q == ~i9)
                      && (chain_nxt == chain_q);
`endif

endmodule
